ezm_seq: RTL and testbench
==========================

EZM_SEQ -- requirements
Module: ezm_seq

Interface
REQ-001 Parameter DEPTH, default 16, program store entries (power of two, 2..16).
REQ-002 Parameter AW, default 4, pc/count width, log2(DEPTH).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wr_valid  in  1  host offers program word.
REQ-006 wr_data  in  6  instruction word for the ezm_cpu in_i encoding.
REQ-007 wr_ready  out  1  store can accept a word.
REQ-008 run  in  1  start/restart execution, level-sampled.
REQ-009 clr  in  1  discard program, return to IDLE.
REQ-010 br_taken  in  1  CPU branch taken this cycle.
REQ-011 br_off  in  8  branch offset, target = pc - br_off.
REQ-012 instr_o  out  6  instruction to CPU.
REQ-013 instr_valid  out  1  instr_o is a real issued instruction.
REQ-014 pc_o  out  AW  current program index.
REQ-015 count_o  out  AW+1  number of stored words.
REQ-016 busy  out  1  state is RUN.
REQ-017 done  out  1  state is DONE.

Function
REQ-018 FSM states IDLE, RUN, DONE; the encoding is free.
REQ-019 wr_ready = IDLE & (count < DEPTH).
REQ-020 wr_valid & wr_ready at an edge: mem[count] <= wr_data and count <= count+1.
REQ-021 IDLE: run & (count after any same-cycle write > 0) moves to RUN with pc <= 0.
REQ-022 IDLE: run with count = 0 is ignored and the block stays in IDLE.
REQ-023 A write and run in the same IDLE cycle both take effect, and the new word is part of the program.
REQ-024 In RUN, instr_valid = 1 and instr_o = mem[pc], read combinationally.
REQ-025 Outside RUN, instr_valid = 0 and instr_o = 6'b000000, the CPU no-op.
REQ-026 RUN without branch: next pc = pc+1; if pc+1 = count, go to DONE.
REQ-027 RUN with br_taken: target = (pc - br_off[AW-1:0]) mod DEPTH, using upper br_off bits as ignored.
REQ-028 Branch target < count: pc <= target and the block stays in RUN.
REQ-029 Branch target >= count: go to DONE, and pc holds.
REQ-030 br_taken is ignored outside RUN.
REQ-031 DONE: run restarts with pc <= 0, RUN, and the program is retained.
REQ-032 clr in any state: state <= IDLE, pc <= 0, count <= 0, with memory contents don't-care.
REQ-033 clr has priority over run, write and branch in the same cycle.
REQ-034 pc_o = pc at all times; busy and done are decoded from state.
REQ-035 Throughput: one instruction per clk in RUN, first instr_valid the cycle after run is sampled.

Reset
REQ-036 rst_n low asynchronously forces state IDLE, pc 0, count 0.
REQ-037 During reset, outputs are instr_o 0, instr_valid 0, wr_ready 1, busy 0, done 0, pc_o 0, count_o 0.
REQ-038 Reset mid-RUN aborts immediately, and no instr_valid is seen after rst_n falls.
REQ-039 Release is synchronous to clk; the first write or run is accepted at the first edge with rst_n high.
REQ-040 Memory array needs no reset.

Configuration
REQ-041 Macro EZM_SEQ_STEP_EN adds input step (in, 1) for single-step execution.
REQ-042 With EZM_SEQ_STEP_EN, RUN outputs instr_valid = step, and instr_o = mem[pc] only when step = 1, else 6'b000000.
REQ-043 With EZM_SEQ_STEP_EN, pc advance, branch and DONE checks occur only on edges where step = 1.
REQ-044 Without EZM_SEQ_STEP_EN, the step port is absent and RUN advances every cycle.

Verification
REQ-045 Load 3 words 0x25,0x11,0x01, then pulse run -> instr_o 0x25,0x11,0x01 on 3 consecutive cycles, then done=1, instr_valid=0.
REQ-046 Load 4 words, run, br_taken=1 with br_off=2 at pc=3 -> next pc=1, execution continues 1,2,3.
REQ-047 Load 2 words, br_taken with br_off=0xFF at pc=0 -> target 1 < count so pc=1; br_off=0x0E at pc=1 -> target 3 >= 2 so DONE.
REQ-048 Write 16 words -> wr_ready=0, and a 17th wr_valid is not stored (count_o stays 16); write plus run in one cycle with count 0 -> RUN issuing that word.
REQ-049 Drop rst_n mid-RUN at pc=2 -> instr_valid 0 and pc_o 0 asynchronously; after release count_o=0 and run is ignored.
REQ-050 With EZM_SEQ_STEP_EN, step high every third cycle -> one instruction per step pulse, pc frozen between pulses, instr_o 0 between pulses.

Source files
------------

// File: rtl/ezm_seq.sv
// ezm_seq: program store and sequencer feeding 6-bit instructions to the ezm_cpu.
// Latency: first instruction issues the cycle after run is sampled, then one per clk.
// Backpressure: wr_ready drops outside IDLE or when the store is full; optional
//   EZM_SEQ_STEP_EN macro adds a step input that gates issue and pc advance.
module ezm_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef EZM_SEQ_STEP_EN
  input  logic          step,
`endif
  input  logic          wr_valid,
  input  logic [5:0]    wr_data,
  output logic          wr_ready,
  input  logic          run,
  input  logic          clr,
  input  logic          br_taken,
  input  logic [7:0]    br_off,
  output logic [5:0]    instr_o,
  output logic          instr_valid,
  output logic [AW-1:0] pc_o,
  output logic [AW:0]   count_o,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [5:0]      mem_q [DEPTH];

  logic            adv;
  logic            wr_fire;
  logic [AW:0]     cnt_wr;
  logic [AW-1:0]   target;
  logic [AW:0]     pc_inc_w;
  logic            unused_br;

  // Only the low AW offset bits matter; the target wraps modulo DEPTH.
  assign unused_br = ^br_off[7:AW];

`ifdef EZM_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign wr_ready = (state_q == ST_IDLE) && (cnt_q < DEPTH_W);
  assign wr_fire  = wr_valid && wr_ready;
  assign cnt_wr   = cnt_q + (AW+1)'(wr_fire);
  assign target   = pc_q - br_off[AW-1:0];
  assign pc_inc_w = {1'b0, pc_q} + (AW+1)'(1);

  // Next-state logic; clr overrides run, writes and branches.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_IDLE;
      pc_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = cnt_wr;
          // A word written this cycle already counts toward the program.
          if (run && (cnt_wr != '0)) begin
            state_d = ST_RUN;
            pc_d    = '0;
          end
        end
        ST_RUN: begin
          if (adv) begin
            if (br_taken) begin
              if ({1'b0, target} < cnt_q) begin
                pc_d = target;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              pc_d = pc_q + AW'(1);
              if (pc_inc_w == cnt_q) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (run) begin
            state_d = ST_RUN;
            pc_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  // State, pc and count registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program store write; contents are not reset and are don't-care after clr.
  always_ff @(posedge clk) begin
    if (wr_fire && !clr) begin
      mem_q[cnt_q[AW-1:0]] <= wr_data;
    end
  end

  assign instr_valid = (state_q == ST_RUN) && adv;
  assign instr_o     = instr_valid ? mem_q[pc_q] : 6'b000000;
  assign pc_o        = pc_q;
  assign count_o     = cnt_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ezm_seq.sv
// Self-checking bench for ezm_seq: scoreboard of expected (pc, instr) pairs.
// Each scenario task drives stimulus and compares issued instructions inline.
// Define EZM_SEQ_STEP_EN to also exercise the single-step variant.
module tb_ezm_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [5:0] wr_data = '0;
  logic       wr_ready;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_off = '0;
  logic [5:0] instr_o;
  logic       instr_valid;
  logic [3:0] pc_o;
  logic [4:0] count_o;
  logic       busy;
  logic       done;
`ifdef EZM_SEQ_STEP_EN
  logic       step = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] pc;
    logic [5:0] ins;
  } exp_t;
  exp_t sbq[$];

  ezm_seq #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef EZM_SEQ_STEP_EN
    .step(step),
`endif
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .run(run), .clr(clr), .br_taken(br_taken), .br_off(br_off),
    .instr_o(instr_o), .instr_valid(instr_valid), .pc_o(pc_o),
    .count_o(count_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc, input int ins);
    exp_t e;
    e.pc  = pc[3:0];
    e.ins = ins[5:0];
    sbq.push_back(e);
  endtask

  task automatic wr(input int w);
    wr_valid = 1'b1;
    wr_data  = w[5:0];
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse_run;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Pops one expectation per cycle; RUN must issue without bubbles.
  // Up to two one-shot branches fire when their pc is issued (pc < 0 disables).
  task automatic drain(input int b0_pc, input int b0_off, input int b1_pc, input int b1_off);
    exp_t e;
    bit   u0 = 1'b0;
    bit   u1 = 1'b0;
    int   budget = 64;
    while (sbq.size() > 0 && budget > 0) begin
      br_taken = 1'b0;
      br_off   = '0;
      n_cmp++;
      if (instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL issue_gap: instr_valid=%b pc_o=%0d, required 1", instr_valid, pc_o);
        sbq.delete();
      end else begin
        e = sbq.pop_front();
        if (instr_o !== e.ins || pc_o !== e.pc) begin
          n_err++;
          $display("FAIL issue: instr_o=%h pc_o=%0d, required instr_o=%h pc_o=%0d",
                   instr_o, pc_o, e.ins, e.pc);
        end
        if (!u0 && b0_pc >= 0 && int'(pc_o) == b0_pc) begin
          br_taken = 1'b1; br_off = b0_off[7:0]; u0 = 1'b1;
        end else if (!u1 && b1_pc >= 0 && int'(pc_o) == b1_pc) begin
          br_taken = 1'b1; br_off = b1_off[7:0]; u1 = 1'b1;
        end
        tick();
      end
      budget--;
    end
    br_taken = 1'b0;
    br_off   = '0;
    if (sbq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d left, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if (instr_o !== 6'h00 || instr_valid !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || pc_o !== 4'd0 || count_o !== 5'd0) begin
      n_err++;
      $display("FAIL reset_outputs: instr=%h v=%b rdy=%b busy=%b done=%b pc=%0d cnt=%0d, required 00 0 1 0 0 0 0",
               instr_o, instr_valid, wr_ready, busy, done, pc_o, count_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    wr(6'h25); wr(6'h11); wr(6'h01);
    n_cmp++;
    if (count_o !== 5'd3) begin n_err++; $display("FAIL basic_count: %0d, required 3", count_o); end
    push(0, 6'h25); push(1, 6'h11); push(2, 6'h01);
    pulse_run();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: %b, required 1", busy); end
    drain(-1, 0, -1, 0);
    n_cmp++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || instr_o !== 6'h00) begin
      n_err++;
      $display("FAIL basic_done: done=%b v=%b instr=%h, required 1 0 00", done, instr_valid, instr_o);
    end
    // Restart from DONE keeps the program.
    push(0, 6'h25); push(1, 6'h11); push(2, 6'h01);
    pulse_run();
    drain(-1, 0, -1, 0);
    n_cmp++;
    if (done !== 1'b1 || count_o !== 5'd3) begin
      n_err++; $display("FAIL restart_done: done=%b cnt=%0d, required 1 3", done, count_o);
    end
    do_clr();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || count_o !== 5'd0 || pc_o !== 4'd0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_idle: done=%b busy=%b cnt=%0d pc=%0d rdy=%b, required 0 0 0 0 1",
               done, busy, count_o, pc_o, wr_ready);
    end
  endtask

  task automatic test_branch;
    wr(6'h0A); wr(6'h1B); wr(6'h2C); wr(6'h3D);
    push(0, 6'h0A); push(1, 6'h1B); push(2, 6'h2C); push(3, 6'h3D);
    push(1, 6'h1B); push(2, 6'h2C); push(3, 6'h3D);
    pulse_run();
    drain(3, 2, -1, 0);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL branch_done: %b, required 1", done); end
    do_clr();
  endtask

  task automatic test_branch_wrap;
    wr(6'h05); wr(6'h06);
    push(0, 6'h05); push(1, 6'h06);
    pulse_run();
    drain(0, 8'hFF, 1, 8'h0E);
    n_cmp++;
    if (done !== 1'b1 || pc_o !== 4'd1) begin
      n_err++; $display("FAIL branch_out: done=%b pc=%0d, required 1 1", done, pc_o);
    end
    do_clr();
  endtask

  task automatic test_full;
    pulse_run();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL run_empty: busy=%b done=%b, required 0 0", busy, done);
    end
    for (int i = 0; i < 16; i++) begin
      wr((i * 5 + 3) & 63);
      push(i, (i * 5 + 3) & 63);
    end
    n_cmp++;
    if (count_o !== 5'd16 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL full: cnt=%0d rdy=%b, required 16 0", count_o, wr_ready);
    end
    wr(6'h3F);
    n_cmp++;
    if (count_o !== 5'd16) begin n_err++; $display("FAIL overfill: cnt=%0d, required 16", count_o); end
    pulse_run();
    drain(-1, 0, -1, 0);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL full_done: %b, required 1", done); end
    do_clr();
    // Write and run in the same IDLE cycle with an empty store.
    wr_valid = 1'b1; wr_data = 6'h2A; run = 1'b1;
    tick();
    wr_valid = 1'b0; run = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || instr_valid !== 1'b1 || instr_o !== 6'h2A || pc_o !== 4'd0 || count_o !== 5'd1) begin
      n_err++;
      $display("FAIL wr_run: busy=%b v=%b instr=%h pc=%0d cnt=%0d, required 1 1 2a 0 1",
               busy, instr_valid, instr_o, pc_o, count_o);
    end
    // clr outranks run, write and branch.
    clr = 1'b1; run = 1'b1; br_taken = 1'b1; wr_valid = 1'b1;
    tick();
    clr = 1'b0; run = 1'b0; br_taken = 1'b0; wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || count_o !== 5'd0 || pc_o !== 4'd0) begin
      n_err++;
      $display("FAIL clr_priority: busy=%b done=%b cnt=%0d pc=%0d, required 0 0 0 0",
               busy, done, count_o, pc_o);
    end
  endtask

  task automatic test_reset_mid;
    int budget = 10;
    wr(6'h01); wr(6'h02); wr(6'h03); wr(6'h04);
    pulse_run();
    while (pc_o != 4'd2 && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (pc_o !== 4'd2 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL reach_pc2: pc=%0d v=%b, required 2 1", pc_o, instr_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || pc_o !== 4'd0 || busy !== 1'b0 || count_o !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: v=%b pc=%0d busy=%b cnt=%0d, required 0 0 0 0",
               instr_valid, pc_o, busy, count_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pulse_run();
    n_cmp++;
    if (count_o !== 5'd0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_run: cnt=%0d busy=%b v=%b, required 0 0 0", count_o, busy, instr_valid);
    end
  endtask

`ifdef EZM_SEQ_STEP_EN
  task automatic test_step;
    exp_t e;
    int   pulses = 0;
    wr(6'h25); wr(6'h11); wr(6'h01);
    push(0, 6'h25); push(1, 6'h11); push(2, 6'h01);
    step = 1'b0;
    pulse_run();
    for (int i = 0; i < 12 && sbq.size() > 0; i++) begin
      step = (i % 3 == 2);
      #1;
      n_cmp++;
      if (step) begin
        e = sbq.pop_front();
        if (instr_valid !== 1'b1 || instr_o !== e.ins || pc_o !== e.pc) begin
          n_err++;
          $display("FAIL step_issue: v=%b instr=%h pc=%0d, required 1 %h %0d",
                   instr_valid, instr_o, pc_o, e.ins, e.pc);
        end
        pulses++;
      end else if (instr_valid !== 1'b0 || instr_o !== 6'h00 || int'(pc_o) != pulses) begin
        n_err++;
        $display("FAIL step_hold: v=%b instr=%h pc=%0d, required 0 00 %0d",
                 instr_valid, instr_o, pc_o, pulses);
      end
      tick();
    end
    step = 1'b1;
    n_cmp++;
    if (sbq.size() != 0 || done !== 1'b1) begin
      n_err++; $display("FAIL step_done: left=%0d done=%b, required 0 1", sbq.size(), done);
    end
    sbq.delete();
    do_clr();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_branch_wrap();
    test_full();
    test_reset_mid();
`ifdef EZM_SEQ_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
